// File: rtl/bind_sig_checker_multi_if.sv
// rtl/bind_sig_checker_multi_if.sv - checker bus bundle for bind_sig_checker_multi
// Ports carried:
//   arm, clear        : control pulses from the harness to the checker
//   sig, ref_val      : observed and expected values, channel i at [i*WIDTH +: WIDTH]
//   sig_copy          : registered copy of sig
//   chg_cnt           : per-channel saturating change counts, channel i at [i*CNT_W +: CNT_W]
//   mismatch          : sticky per-channel mismatch flags
//   busy, all_ok      : reductions over the channel state machines
interface bind_sig_checker_multi_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
) ();
  logic                      arm;
  logic                      clear;
  logic [CHANNELS*WIDTH-1:0] sig;
  logic [CHANNELS*WIDTH-1:0] ref_val;
  logic [CHANNELS*WIDTH-1:0] sig_copy;
  logic [CHANNELS*CNT_W-1:0] chg_cnt;
  logic [CHANNELS-1:0]       mismatch;
  logic                      busy;
  logic                      all_ok;

  modport master (
    output arm, clear, sig, ref_val,
    input  sig_copy, chg_cnt, mismatch, busy, all_ok
  );

  modport slave (
    input  arm, clear, sig, ref_val,
    output sig_copy, chg_cnt, mismatch, busy, all_ok
  );
endinterface

// File: rtl/bind_sig_checker_multi.sv
// rtl/bind_sig_checker_multi.sv - multi-channel registered-copy / change-count / compare checker
// Ports:
//   clk   : single clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bind_sig_checker_multi_if (arm, clear, sig, ref_val in;
//           sig_copy, chg_cnt, mismatch, busy, all_ok out)
module bind_sig_checker_multi #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8,
  parameter int SETTLE   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  bind_sig_checker_multi_if.slave       bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FAIL   = 2'd3
  } state_e;

  // Settle counter is kept at least one bit wide so SETTLE=0 still elaborates.
  localparam int SCW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SETTLE_INIT = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [SCW-1:0]   SCNT_LOAD = SCW'(SETTLE_INIT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [CHANNELS*WIDTH-1:0] sig_copy_d, sig_copy_q;
  logic [CHANNELS-1:0]       busy_vec;
  logic [CHANNELS-1:0]       ok_vec;

  // sig_copy ignores clear; it is purely a one-cycle delayed image of sig.
  always_comb begin
    sig_copy_d = bus.sig;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_copy_q <= '0;
    end else begin
      sig_copy_q <= sig_copy_d;
    end
  end

  assign bus.sig_copy = sig_copy_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e           state_d, state_q;
    logic [SCW-1:0]   scnt_d, scnt_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             mm_d, mm_q;
    logic [WIDTH-1:0] sig_i, ref_i, copy_i;

    assign sig_i  = bus.sig[i*WIDTH +: WIDTH];
    assign ref_i  = bus.ref_val[i*WIDTH +: WIDTH];
    assign copy_i = sig_copy_q[i*WIDTH +: WIDTH];

    always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      cnt_d   = cnt_q;
      mm_d    = mm_q;

      // Change counting runs in every state and saturates instead of wrapping.
      if ((sig_i != copy_i) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      unique case (state_q)
        ST_IDLE: begin
          if (bus.arm) begin
            if (SETTLE == 0) begin
              state_d = ST_CHECK;
            end else begin
              state_d = ST_SETTLE;
              scnt_d  = SCNT_LOAD;
            end
          end
        end
        ST_SETTLE: begin
          // Loaded with SETTLE-1, so leaving at zero gives exactly SETTLE cycles here.
          if (scnt_q == '0) begin
            state_d = ST_CHECK;
          end else begin
            scnt_d = scnt_q - SCW'(1);
          end
        end
        ST_CHECK: begin
          if (sig_i != ref_i) begin
            state_d = ST_FAIL;
            mm_d    = 1'b1;
          end
        end
        ST_FAIL: begin
          mm_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // clear overrides arm, change counting and mismatch capture in the same cycle.
      if (bus.clear) begin
        state_d = ST_IDLE;
        scnt_d  = '0;
        cnt_d   = '0;
        mm_d    = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        scnt_q  <= '0;
        cnt_q   <= '0;
        mm_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        scnt_q  <= scnt_d;
        cnt_q   <= cnt_d;
        mm_q    <= mm_d;
      end
    end

    assign bus.chg_cnt[i*CNT_W +: CNT_W] = cnt_q;
    assign bus.mismatch[i]               = mm_q;
    assign busy_vec[i]                   = (state_q == ST_SETTLE);
    assign ok_vec[i]                     = (state_q == ST_CHECK) && !mm_q;
  end

  // Both reductions come only from flops, so there is no input-to-output path.
  assign bus.busy   = |busy_vec;
  assign bus.all_ok = &ok_vec;

endmodule

// File: tb/tb_bind_sig_checker_multi.sv
// tb/tb_bind_sig_checker_multi.sv - directed table-driven bench for bind_sig_checker_multi
module tb_bind_sig_checker_multi;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bind_sig_checker_multi_if                  if_a ();
  bind_sig_checker_multi_if                  if_b ();
  bind_sig_checker_multi_if #(.CNT_W(3))     if_c ();
  bind_sig_checker_multi_if                  if_d ();

  bind_sig_checker_multi                     dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  bind_sig_checker_multi                     dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  bind_sig_checker_multi #(.CNT_W(3))        dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  bind_sig_checker_multi #(.SETTLE(0))       dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        arm;
    logic        clear;
    logic [1:0]  sig;
    logic [1:0]  ref_v;
    logic [1:0]  e_copy;
    logic [15:0] e_cnt;
    logic [1:0]  e_mm;
    logic        e_busy;
    logic        e_ok;
  } vec_t;

  vec_t tbl[16];

  initial begin
    //            arm   clr   sig    ref    copy   cnt       mm     busy  ok
    tbl[0]  = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 16'h0000, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b01, 16'h0000, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b01, 16'h0000, 2'b00, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b01, 16'h0000, 2'b00, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b01, 16'h0000, 2'b00, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b01, 16'h0000, 2'b00, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 16'h0100, 2'b00, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 2'b01, 2'b11, 2'b01, 16'h0200, 2'b10, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 16'h0300, 2'b10, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 2'b11, 2'b11, 2'b11, 16'h0300, 2'b10, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 16'h0300, 2'b10, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 2'b10, 2'b11, 2'b10, 16'h0000, 2'b00, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 2'b10, 2'b10, 2'b10, 16'h0000, 2'b00, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 2'b10, 2'b10, 2'b10, 16'h0000, 2'b00, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 2'b10, 2'b10, 2'b10, 16'h0000, 2'b00, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 2'b10, 2'b10, 2'b10, 16'h0000, 2'b00, 1'b0, 1'b1};

    rst_n = 1'b0;
    if_a.arm = 1'b0; if_a.clear = 1'b0; if_a.sig = 2'b11; if_a.ref_val = 2'b00;
    if_b.arm = 1'b0; if_b.clear = 1'b0; if_b.sig = 2'b11; if_b.ref_val = 2'b00;
    if_c.arm = 1'b0; if_c.clear = 1'b0; if_c.sig = 2'b00; if_c.ref_val = 2'b00;
    if_d.arm = 1'b0; if_d.clear = 1'b0; if_d.sig = 2'b00; if_d.ref_val = 2'b00;

    // Reset state holds while clocks run with nonzero sig.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_copy",  32'(if_a.sig_copy), 32'h0);
    chk("rst_cnt",   32'(if_a.chg_cnt),  32'h0);
    chk("rst_mm",    32'(if_a.mismatch), 32'h0);
    chk("rst_busy",  32'(if_a.busy),     32'h0);
    chk("rst_ok",    32'(if_a.all_ok),   32'h0);

    // Two instances, sig held at 11 from reset.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("inst_a_copy", 32'(if_a.sig_copy), 32'h3);
    chk("inst_a_cnt1", 32'(if_a.chg_cnt),  32'h0101);
    chk("inst_b_copy", 32'(if_b.sig_copy), 32'h3);
    chk("inst_b_cnt1", 32'(if_b.chg_cnt),  32'h0101);
    repeat (10) @(posedge clk);
    #1;
    chk("inst_a_cnt11", 32'(if_a.chg_cnt), 32'h0101);
    chk("inst_b_cnt11", 32'(if_b.chg_cnt), 32'h0101);

    // Arm/settle/check, sticky mismatch, ignored re-arm, clear+arm.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if_a.arm     = tbl[k].arm;
      if_a.clear   = tbl[k].clear;
      if_a.sig     = tbl[k].sig;
      if_a.ref_val = tbl[k].ref_v;
      @(posedge clk); #1;
      chk($sformatf("row%0d_copy", k), 32'(if_a.sig_copy), 32'(tbl[k].e_copy));
      chk($sformatf("row%0d_cnt",  k), 32'(if_a.chg_cnt),  32'(tbl[k].e_cnt));
      chk($sformatf("row%0d_mm",   k), 32'(if_a.mismatch), 32'(tbl[k].e_mm));
      chk($sformatf("row%0d_busy", k), 32'(if_a.busy),     32'(tbl[k].e_busy));
      chk($sformatf("row%0d_ok",   k), 32'(if_a.all_ok),   32'(tbl[k].e_ok));
    end
    @(negedge clk);
    if_a.arm = 1'b0;

    // Saturation with a 3-bit counter.
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if_c.sig[0] = ~if_c.sig[0];
      @(posedge clk); #1;
      chk($sformatf("sat%0d_ch0", k), 32'(if_c.chg_cnt[2:0]), (k > 7) ? 32'd7 : 32'(k));
      chk($sformatf("sat%0d_ch1", k), 32'(if_c.chg_cnt[5:3]), 32'd0);
    end

    // SETTLE=0: arm goes straight to CHECK; asynchronous reset mid-CHECK.
    @(negedge clk);
    if_d.sig = 2'b01; if_d.ref_val = 2'b01; if_d.arm = 1'b1;
    @(posedge clk); #1;
    chk("s0_ok_arm",  32'(if_d.all_ok),  32'h1);
    chk("s0_cnt_arm", 32'(if_d.chg_cnt), 32'h0001);
    chk("s0_busy",    32'(if_d.busy),    32'h0);
    @(negedge clk);
    if_d.arm = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_ok",   32'(if_d.all_ok),   32'h0);
    chk("async_cnt",  32'(if_d.chg_cnt),  32'h0);
    chk("async_copy", 32'(if_d.sig_copy), 32'h0);
    chk("async_mm",   32'(if_d.mismatch), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    if_d.arm = 1'b1;
    @(posedge clk); #1;
    chk("rearm_ok",   32'(if_d.all_ok),   32'h1);
    chk("rearm_copy", 32'(if_d.sig_copy), 32'h1);
    chk("rearm_cnt",  32'(if_d.chg_cnt),  32'h0001);
    @(negedge clk);
    if_d.arm = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
